dcache: RTL

Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the shared data memory. It serves 8-bit loads and stores from the ALU-computed address. It returns load data to the register-file write path and stalls the CPU through BUSYWAIT. On a miss it fetches and evicts whole 4-byte blocks over a handshaked memory port.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_ctrl.sv | 66 ++++++
 rtl/dcache.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared widths, FSM state encoding and helpers for the data cache.
// Revision : 1.0
// ============================================================================
package dcache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;
    localparam int BLOCK_W    = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    function automatic logic [MEM_ADDR_W-1:0] block_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Miss-handling FSM; memory strobes are registered from next state.
// Revision : 1.0
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    input  logic   hit,
    input  logic   dirty,
    input  logic   READ,
    input  logic   WRITE,
    input  logic   MEM_BUSYWAIT,
    output state_t state,
    output logic   MEM_READ,
    output logic   MEM_WRITE,
    output logic   update
);

    state_t r_state;
    state_t w_next_state;
    logic   r_mem_read;
    logic   r_mem_write;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_mem_read  <= (w_next_state == FETCH);
            r_mem_write <= (w_next_state == WRITEBACK);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if ((READ || WRITE) && !hit)
                    w_next_state = dirty ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                if (!MEM_BUSYWAIT)
                    w_next_state = FETCH;
            end
            FETCH: begin
                if (!MEM_BUSYWAIT)
                    w_next_state = UPDATE;
            end
            UPDATE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign state     = r_state;
    assign MEM_READ  = r_mem_read;
    assign MEM_WRITE = r_mem_write;
    assign update    = (r_state == UPDATE);

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Brief    : Direct-mapped write-back, write-allocate byte data cache.
// Revision : 1.0
// ============================================================================
module dcache
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [NUM_BLOCKS-1:0]        r_valid;
    logic [NUM_BLOCKS-1:0]        r_dirty;
    logic [TAG_W-1:0]             r_tag  [NUM_BLOCKS];
    logic [BLOCK_BYTES-1:0][7:0]  r_data [NUM_BLOCKS];

    logic [MEM_ADDR_W-1:0]        r_req_addr;
    logic [MEM_ADDR_W-1:0]        r_wb_addr;
    logic [BLOCK_W-1:0]           r_wb_data;

    logic [TAG_W-1:0]             w_tag;
    logic [INDEX_W-1:0]           w_index;
    logic [OFFSET_W-1:0]          w_offset;
    logic [TAG_W-1:0]             w_fill_tag;
    logic [INDEX_W-1:0]           w_fill_index;
    logic                         w_req;
    logic                         w_hit;
    logic                         w_dirty;
    logic                         w_update;
    logic                         w_miss_start;
    logic                         w_write_hit;
    state_t                       w_state;

    assign w_tag        = ADDRESS[ADDR_W-1 -: TAG_W];
    assign w_index      = ADDRESS[OFFSET_W +: INDEX_W];
    assign w_offset     = ADDRESS[OFFSET_W-1:0];
    assign w_fill_tag   = r_req_addr[MEM_ADDR_W-1 -: TAG_W];
    assign w_fill_index = r_req_addr[INDEX_W-1:0];

    assign w_req        = READ || WRITE;
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_dirty      = r_valid[w_index] && r_dirty[w_index];
    assign w_miss_start = (w_state == IDLE) && w_req && !w_hit;
    // A simultaneous READ and WRITE is a store, so WRITE alone decides.
    assign w_write_hit  = (w_state == IDLE) && WRITE && w_hit;

    dcache_ctrl u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .hit          (w_hit),
        .dirty        (w_dirty),
        .READ         (READ),
        .WRITE        (WRITE),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .state        (w_state),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .update       (w_update)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_update) begin
            r_valid[w_fill_index] <= 1'b1;
            r_dirty[w_fill_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_update) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= MEM_READDATA;
        end else if (w_write_hit) begin
            r_data[w_index][w_offset] <= WRITEDATA;
        end
    end

    // Miss context is latched so the transfer completes even if the CPU
    // withdraws or changes its request mid-miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_req_addr <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_miss_start) begin
            r_req_addr <= ADDRESS[ADDR_W-1:OFFSET_W];
            if (w_dirty) begin
                r_wb_addr <= block_addr(r_tag[w_index], w_index);
                r_wb_data <= r_data[w_index];
            end
        end
    end

    assign MEM_ADDRESS   = (w_state == WRITEBACK) ? r_wb_addr : r_req_addr;
    assign MEM_WRITEDATA = r_wb_data;
    assign READDATA      = r_data[w_index][w_offset];
    assign BUSYWAIT      = w_req && ((w_state != IDLE) || !w_hit);

endmodule
`default_nettype wire
